fifo_wr_arbiter: RTL and testbench

//  Round-robin arbiter sharing one async-FIFO write port among NUM_REQ requesters in the wclk domain.

---
 rtl/fifo_wr_arbiter_pkg.sv | 36 +++
 rtl/fifo_wr_arbiter_if.sv | 28 ++
 rtl/fifo_wr_arbiter_rr_pick_core.sv | 18 +
 rtl/fifo_wr_arbiter.sv | 98 +++++++++
 tb/tb_fifo_wr_arbiter.sv | 196 +++++++++++++++++++
 5 files changed

// File: rtl/fifo_wr_arbiter_pkg.sv
// Shared types and helpers for the round-robin FIFO write-port arbiter (package fifo_arb_pkg).
// The search function works on a 16-bit request vector; narrower callers zero-extend.
package fifo_arb_pkg;

   typedef enum logic {ARB_IDLE = 1'b0, ARB_BUSY = 1'b1} arb_state_e;

   localparam int MAX_REQ  = 16;
   localparam int MAX_ID_W = 4;

   function automatic int id_width(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

   typedef struct packed {
      logic                found;
      logic [MAX_ID_W-1:0] idx;
   } pick_t;

   // Unused upper request bits are zero, so a mod-16 walk from ptr < NUM_REQ
   // visits the real requesters in the same order as a mod-NUM_REQ walk.
   function automatic pick_t rr_pick(input logic [MAX_REQ-1:0] req,
                                     input logic [MAX_ID_W-1:0] ptr);
      pick_t               res;
      logic [MAX_ID_W-1:0] j;
      res = '0;
      for (int i = MAX_REQ - 1; i >= 0; i--) begin
         j = ptr + MAX_ID_W'(i);
         if (req[j]) begin
            res.found = 1'b1;
            res.idx   = j;
         end
      end
      return res;
   endfunction

endpackage

// File: rtl/fifo_wr_arbiter_if.sv
// Requester, FIFO-write and status signals of the arbiter. slave = arbiter view, master = environment.
// Handshake: beat i moves in a cycle where req_valid[i] & req_ready[i]; winc marks the same beat.
interface fifo_wr_arbiter_if #(
   parameter int NUM_REQ   = 4,
   parameter int DATA_SIZE = 8
);
   localparam int ID_W = fifo_arb_pkg::id_width(NUM_REQ);

   logic [NUM_REQ-1:0]           req_valid;
   logic [NUM_REQ*DATA_SIZE-1:0] req_data;
   logic [NUM_REQ-1:0]           req_last;
   logic [NUM_REQ-1:0]           req_ready;
   logic                         wfull;
   logic                         winc;
   logic [DATA_SIZE-1:0]         wdata;
   logic [ID_W-1:0]              gnt_id;
   logic                         busy;

   modport slave (
      input  req_valid, req_data, req_last, wfull,
      output req_ready, winc, wdata, gnt_id, busy
   );

   modport master (
      output req_valid, req_data, req_last, wfull,
      input  req_ready, winc, wdata, gnt_id, busy
   );
endinterface

// File: rtl/fifo_wr_arbiter_rr_pick_core.sv
// Combinational rotate-and-priority search: first set request at or after ptr, wrapping.
module rr_pick_core
   import fifo_arb_pkg::*;
#(
   parameter  int NUM_REQ = 4,
   localparam int ID_W    = id_width(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [ID_W-1:0]    ptr,
   output logic               found,
   output logic [ID_W-1:0]    idx
);
   pick_t pick;

   assign pick  = rr_pick(MAX_REQ'(req), MAX_ID_W'(ptr));
   assign found = pick.found;
   assign idx   = pick.idx[ID_W-1:0];
endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter driving one async-FIFO write port from NUM_REQ requesters (wclk domain).
// Define FIFO_WR_ARB_PKT_LOCK_EN to hold the grant until the last beat of a packet.
module fifo_wr_arbiter
   import fifo_arb_pkg::*;
#(
   parameter int NUM_REQ   = 4,
   parameter int DATA_SIZE = 8
) (
   input logic            wclk,
   input logic            wrst,
   fifo_wr_arbiter_if.slave bus
);
   localparam int ID_W = id_width(NUM_REQ);

   arb_state_e      state_q, state_d;
   logic [ID_W-1:0] owner_q, owner_d;
   logic [ID_W-1:0] rr_ptr_q, rr_ptr_d;
   logic [ID_W-1:0] next_ptr, search_ptr, pick_idx;
   logic            pick_found;
   logic            own_valid;
   logic            xfer;
   logic            release_own;

   always_comb begin
      if (int'(owner_q) == NUM_REQ - 1) next_ptr = '0;
      else                              next_ptr = owner_q + 1'b1;
   end

   // A release re-arbitrates from owner+1 in the same cycle, so one search serves both states.
   assign search_ptr = (state_q == ARB_BUSY) ? next_ptr : rr_ptr_q;

   rr_pick_core #(.NUM_REQ(NUM_REQ)) u_pick (
      .req   (bus.req_valid),
      .ptr   (search_ptr),
      .found (pick_found),
      .idx   (pick_idx)
   );

   always_comb begin
      state_d       = state_q;
      owner_d       = owner_q;
      rr_ptr_d      = rr_ptr_q;
      own_valid     = bus.req_valid[owner_q];
      xfer          = 1'b0;
      release_own   = 1'b0;
      bus.winc      = 1'b0;
      bus.req_ready = '0;
      bus.wdata     = bus.req_data[int'(owner_q)*DATA_SIZE +: DATA_SIZE];
      bus.busy      = 1'b0;
      bus.gnt_id    = owner_q;

      case (state_q)
         ARB_IDLE: begin
            if (pick_found) begin
               state_d = ARB_BUSY;
               owner_d = pick_idx;
            end
         end
         ARB_BUSY: begin
            bus.busy               = 1'b1;
            bus.req_ready[owner_q] = ~bus.wfull;
            xfer                   = own_valid & ~bus.wfull;
            bus.winc               = xfer;
`ifdef FIFO_WR_ARB_PKT_LOCK_EN
            release_own = xfer & bus.req_last[owner_q];
`else
            // A full FIFO freezes the owner even if it drops valid.
            release_own = xfer | (~own_valid & ~bus.wfull);
`endif
            if (release_own) begin
               rr_ptr_d = next_ptr;
               if (pick_found) owner_d = pick_idx;
               else            state_d = ARB_IDLE;
            end
         end
         default: state_d = ARB_IDLE;
      endcase

      if (wrst) begin
         bus.winc      = 1'b0;
         bus.req_ready = '0;
         bus.busy      = 1'b0;
         bus.gnt_id    = '0;
      end
   end

   always_ff @(posedge wclk) begin
      if (wrst) begin
         state_q  <= ARB_IDLE;
         owner_q  <= '0;
         rr_ptr_q <= '0;
      end else begin
         state_q  <= state_d;
         owner_q  <= owner_d;
         rr_ptr_q <= rr_ptr_d;
      end
   end
endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Self-checking bench for fifo_wr_arbiter: directed scenarios then random traffic against a reference model.
// Honours FIFO_WR_ARB_PKT_LOCK_EN the same way as the design.
module tb_fifo_wr_arbiter;
   localparam int N  = 4;
   localparam int DS = 8;

   logic wclk = 1'b0;
   logic wrst;

   always #5 wclk = ~wclk;

   fifo_wr_arbiter_if #(.NUM_REQ(N), .DATA_SIZE(DS)) bus ();

   fifo_wr_arbiter #(.NUM_REQ(N), .DATA_SIZE(DS)) dut (
      .wclk (wclk),
      .wrst (wrst),
      .bus  (bus)
   );

   int n_tests = 0;
   int n_fail  = 0;

   int m_busy  = 0;
   int m_owner = 0;
   int m_ptr   = 0;
   logic [31:0] exp_q[$];

   logic          obs_winc;
   logic [N-1:0]  obs_ready;
   logic          obs_busy;
   logic [1:0]    obs_gnt;
   logic [DS-1:0] obs_wdata;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   function automatic int ref_pick(input logic [N-1:0] v, input int ptr);
      for (int k = 0; k < N; k++)
         if (v[(ptr + k) % N]) return (ptr + k) % N;
      return -1;
   endfunction

   // One clock: drive at negedge, check mid-low phase, advance the model for the next edge.
   task automatic step(input logic rst, input logic [N-1:0] v, input logic [N*DS-1:0] d,
                       input logic [N-1:0] last, input logic full);
      int            p;
      logic          fire, rel;
      logic [N-1:0]  exp_ready;
      @(negedge wclk);
      wrst          = rst;
      bus.req_valid = v;
      bus.req_data  = d;
      bus.req_last  = last;
      bus.wfull     = full;
      #1;
      obs_winc  = bus.winc;
      obs_ready = bus.req_ready;
      obs_busy  = bus.busy;
      obs_gnt   = bus.gnt_id;
      obs_wdata = bus.wdata;
      if (rst) begin
         check_eq("rst_winc", 32'(obs_winc), 0);
         check_eq("rst_ready", 32'(obs_ready), 0);
         check_eq("rst_busy", 32'(obs_busy), 0);
         check_eq("rst_gnt", 32'(obs_gnt), 0);
         m_busy = 0; m_owner = 0; m_ptr = 0;
      end else if (m_busy == 0) begin
         check_eq("idle_winc", 32'(obs_winc), 0);
         check_eq("idle_ready", 32'(obs_ready), 0);
         check_eq("idle_busy", 32'(obs_busy), 0);
         p = ref_pick(v, m_ptr);
         if (p >= 0) begin m_busy = 1; m_owner = p; end
      end else begin
         fire      = v[m_owner] && !full;
         exp_ready = full ? '0 : N'(1 << m_owner);
         check_eq("winc", 32'(obs_winc), 32'(fire));
         check_eq("ready", 32'(obs_ready), 32'(exp_ready));
         check_eq("busy", 32'(obs_busy), 1);
         check_eq("gnt", 32'(obs_gnt), 32'(m_owner));
         if (fire) exp_q.push_back(32'(d[m_owner*DS +: DS]));
`ifdef FIFO_WR_ARB_PKT_LOCK_EN
         rel = fire && last[m_owner];
`else
         rel = fire || (!v[m_owner] && !full);
`endif
         if (rel) begin
            m_ptr = (m_owner + 1) % N;
            p = ref_pick(v, m_ptr);
            if (p >= 0) m_owner = p;
            else        m_busy = 0;
         end
      end
      if (obs_winc === 1'b1) begin
         if (exp_q.size() == 0) check_eq("sb_unexpected_beat", 1, 0);
         else                   check_eq("sb_wdata", 32'(obs_wdata), exp_q.pop_front());
      end
   endtask

   localparam logic [N*DS-1:0] DDAT = 32'hD3C2B1A0;

   initial begin
      logic [N*DS-1:0] rd;
      logic [N-1:0]    rl;
      wrst = 1'b1;
      bus.req_valid = '0; bus.req_data = '0; bus.req_last = '0; bus.wfull = 1'b0;

      // reset with all requesters valid
      step(1, 4'hF, DDAT, 4'hF, 0);
      step(1, 4'hF, DDAT, 4'hF, 0);
      check_eq("t1_busy", 32'(obs_busy), 0);
      check_eq("t1_winc", 32'(obs_winc), 0);
      step(0, 4'hF, DDAT, 4'hF, 0);
      check_eq("t1_idle_cycle", 32'(obs_busy), 0);

      // fairness rotation, one beat each
      for (int k = 0; k < 5; k++) begin
         step(0, 4'hF, DDAT, 4'hF, 0);
         check_eq("t2_gnt", 32'(obs_gnt), 32'(k % 4));
         check_eq("t2_winc", 32'(obs_winc), 1);
         check_eq("t2_wdata", 32'(obs_wdata), 32'(DDAT[(k % 4)*DS +: DS]));
      end

      // wfull stall holds owner 2, then one beat and rotate to 3
      step(1, 4'h0, DDAT, 4'hF, 0);
      step(0, 4'b0100, DDAT, 4'hF, 0);
      for (int k = 0; k < 5; k++) begin
         step(0, 4'b0100, DDAT, 4'hF, 1);
         check_eq("t3_stall_winc", 32'(obs_winc), 0);
         check_eq("t3_stall_gnt", 32'(obs_gnt), 2);
         check_eq("t3_stall_ready", 32'(obs_ready), 0);
      end
      step(0, 4'b1100, DDAT, 4'hF, 0);
      check_eq("t3_beat", 32'(obs_winc), 1);

      // owner 3 wraps to requester 0 without a bubble
      step(0, 4'b1001, DDAT, 4'hF, 0);
      check_eq("t5_gnt3", 32'(obs_gnt), 3);
      step(0, 4'b0001, DDAT, 4'hF, 0);
      check_eq("t5_gnt0", 32'(obs_gnt), 0);
      check_eq("t5_nobubble", 32'(obs_winc), 1);

      // reset while busy: ownership dropped, fresh arbitration afterwards
      step(1, 4'b0001, DDAT, 4'h0, 0);
      step(0, 4'b0000, DDAT, 4'h0, 0);
      check_eq("t6_idle", 32'(obs_busy), 0);
      step(0, 4'b0010, DDAT, 4'hF, 0);
      step(0, 4'b0010, DDAT, 4'hF, 0);
      check_eq("t6_regrant", 32'(obs_gnt), 1);

`ifdef FIFO_WR_ARB_PKT_LOCK_EN
      // packet lock: req1 keeps grant across a valid gap while req0 waits
      step(1, 4'h0, DDAT, 4'h0, 0);
      step(0, 4'b0001, DDAT, 4'h0, 0);
      step(0, 4'b0011, DDAT, 4'hF, 0);
      step(0, 4'b0011, DDAT, 4'h0, 0);
      check_eq("t4_b1", 32'(obs_gnt), 1);
      step(0, 4'b0011, DDAT, 4'h0, 0);
      check_eq("t4_b2", 32'(obs_gnt), 1);
      for (int k = 0; k < 2; k++) begin
         step(0, 4'b0001, DDAT, 4'h0, 0);
         check_eq("t4_gap_gnt", 32'(obs_gnt), 1);
         check_eq("t4_gap_winc", 32'(obs_winc), 0);
      end
      step(0, 4'b0011, DDAT, 4'h0, 0);
      check_eq("t4_b3", 32'(obs_gnt), 1);
      step(0, 4'b0011, DDAT, 4'b0010, 0);
      check_eq("t4_b4", 32'(obs_gnt), 1);
      step(0, 4'b0001, DDAT, 4'h0, 0);
      check_eq("t4_next", 32'(obs_gnt), 0);
      // reset mid-packet of req0; packet is not resumed
      step(1, 4'b0001, DDAT, 4'h0, 0);
      step(0, 4'b0000, DDAT, 4'h0, 0);
      check_eq("t6_lock_idle", 32'(obs_busy), 0);
      step(0, 4'b0010, DDAT, 4'h0, 0);
      step(0, 4'b0011, DDAT, 4'h0, 0);
      check_eq("t6_lock_regrant", 32'(obs_gnt), 1);
`endif

      // random traffic
      for (int c = 0; c < 3000; c++) begin
         rd = $urandom;
         for (int i = 0; i < N; i++) rl[i] = ($urandom_range(0, 2) == 0);
         step(($urandom_range(0, 99) == 0), N'($urandom_range(0, 15)), rd, rl,
              ($urandom_range(0, 3) == 0));
      end

      check_eq("sb_drain", 32'(exp_q.size()), 0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
